bist_controller: RTL

Sequencing FSM for the per-scan BIST wrapper around the 4-requester arbiter in top_level. On a bist_start rising edge it switches the wrapper into test mode and clears the pattern LFSR and response MISR. It then runs N_PATTERNS shift/capture rounds over the scan chain and a final flush, compares the MISR signature against a golden value, and reports bist_end / pass_nfail. It drives only control strobes; the LFSR, MISR, scan muxes and chain stay in the datapath.

---
 rtl/bist_controller_pkg.sv | 55 +++++
 rtl/bist_down_counter.sv | 28 ++
 rtl/bist_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/bist_controller_pkg.sv
// Shared definitions for the BIST sequencing controller: state encoding,
// strobe bundle and the state-to-strobe decode.
package bist_controller_pkg;

    localparam int          SIG_W_DEFAULT      = 16;
    localparam logic [15:0] GOLDEN_SIG_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        FLUSH   = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } state_t;

    typedef struct packed {
        logic bist_mode;
        logic scan_en;
        logic lfsr_init;
        logic misr_init;
        logic lfsr_en;
        logic misr_en;
    } strobes_t;

    // Strobes depend only on the state register, so they are glitch-free
    // with respect to the inputs and drop together on reset.
    function automatic strobes_t decode_strobes(state_t state);
        strobes_t s;
        s = '0;
        case (state)
            INIT: begin
                s.bist_mode = 1'b1;
                s.lfsr_init = 1'b1;
                s.misr_init = 1'b1;
            end
            SHIFT: begin
                s.bist_mode = 1'b1;
                s.scan_en   = 1'b1;
                s.lfsr_en   = 1'b1;
                s.misr_en   = 1'b1;
            end
            CAPTURE, COMPARE: s.bist_mode = 1'b1;
            FLUSH: begin
                s.bist_mode = 1'b1;
                s.scan_en   = 1'b1;
                s.misr_en   = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bist_down_counter.sv
// Loadable down counter with a zero flag; holds at zero instead of wrapping.
module bist_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bist_controller.sv
// BIST sequencing FSM: INIT, N_PATTERNS shift/capture rounds, flush, then a
// signature compare; drives only control strobes for the scan datapath.
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int                CHAIN_LEN  = 8,
    parameter int                N_PATTERNS = 100,
    parameter int                SIG_W      = SIG_W_DEFAULT,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = SIG_W'(GOLDEN_SIG_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             bist_mode,
    output logic             scan_en,
    output logic             lfsr_init,
    output logic             misr_init,
    output logic             lfsr_en,
    output logic             misr_en,
    output logic             bist_end,
    output logic             pass_nfail
);

    localparam int SHIFT_W = $clog2(CHAIN_LEN + 1);
    localparam int PAT_W   = $clog2(N_PATTERNS + 1);

    state_t   state;
    strobes_t strobes;
    logic     start_q;
    logic     start;
    logic     shift_zero;
    logic     pat_zero;

    assign start = bist_start & ~start_q;

    // Shift counter serves both SHIFT and FLUSH; CAPTURE reloads it.
    bist_down_counter #(.WIDTH(SHIFT_W)) u_shift_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (state == INIT || state == CAPTURE),
        .load_value (SHIFT_W'(CHAIN_LEN - 1)),
        .dec        (state == SHIFT || state == FLUSH),
        .zero       (shift_zero)
    );

    bist_down_counter #(.WIDTH(PAT_W)) u_pat_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (state == INIT),
        .load_value (PAT_W'(N_PATTERNS - 1)),
        .dec        (state == CAPTURE),
        .zero       (pat_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            bist_end   <= 1'b0;
            pass_nfail <= 1'b0;
        end else begin
            start_q <= bist_start;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= INIT;
                        bist_end   <= 1'b0;
                        pass_nfail <= 1'b0;
                    end
                end
                INIT:    state <= SHIFT;
                SHIFT:   if (shift_zero) state <= CAPTURE;
                CAPTURE: state <= pat_zero ? FLUSH : SHIFT;
                FLUSH:   if (shift_zero) state <= COMPARE;
                COMPARE: begin
                    pass_nfail <= (misr_sig == GOLDEN_SIG);
                    bist_end   <= 1'b1;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign strobes   = decode_strobes(state);
    assign bist_mode = strobes.bist_mode;
    assign scan_en   = strobes.scan_en;
    assign lfsr_init = strobes.lfsr_init;
    assign misr_init = strobes.misr_init;
    assign lfsr_en   = strobes.lfsr_en;
    assign misr_en   = strobes.misr_en;

endmodule
